pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised decode, ID/EX control register and hazard controller for the five-stage RV32 pipeline. It decodes the ID-stage instruction into EX/MEM/WB control bits and registers them into the ID/EX stage. It raises load-use stalls, branch flushes and multi-cycle multiply holds to the IF and ID stages. It replaces the purely combinational decoder and adds the sequential hazard handling that decoder lacked.

## Interface
Parameters:
- MUL_LAT, 3: cycles a `mul` occupies EX. Range 1..15.
- REG_AW, 5: register index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- inst_i  in  32  instruction in ID
- id_valid_i  in  1  inst_i is a real instruction; 0 decodes as bubble
- branch_taken_i  in  1  beq in EX resolved taken (from EX comparator)
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  zero IF/ID next edge
- ex_aluop_o  out  3  ALU op of instruction in EX
- ex_alusrc_o  out  1  1 = immediate operand
- ex_memread_o / ex_memwrite_o / ex_memtoreg_o / ex_regwrite_o / ex_branch_o  out  1 each
- ex_rd_o  out  REG_AW  destination of instruction in EX
- mul_busy_o  out  1  multiply hold in progress
- illegal_o  out  1  registered; EX holds an undecodable instruction (converted to bubble)

## Operation
- Decode: opcode inst_i[6:0], funct3 [14:12], funct7 [31:25]. Supported: add, sub, and, or, mul (R-type 0110011), addi (0010011), lw (0000011), sw (0100011), beq (1100011). Anything else: all control 0, illegal bit set.
- ALU op: ADD 000, AND 001, OR 010, SUB 011, MUL 101, CMP 110. lw/sw/addi use ADD with alusrc=1. beq uses CMP, branch=1.
- rs2 is "used" only by R-type, sw and beq. rd is forced to 0 for sw and beq.
- Load-use stall (combinational): ex_memread_o && ex_rd_o!=0 && (ex_rd_o==rs1 || (rs2 used && ex_rd_o==rs2)). Effect: pc_write_o=0, ifid_write_o=0, bubble (all control 0, rd 0) into ID/EX at the next edge.
- Branch flush: branch_taken_i=1 gives ifid_flush_o=1 and a bubble into ID/EX. PC write stays 1 so the target loads.
- Mul hold, FSM states:
  - RUN to MUL_WAIT when a mul is latched into ID/EX and MUL_LAT>1. The counter loads MUL_LAT-1.
  - MUL_WAIT: ID/EX holds its value, pc_write_o=0, ifid_write_o=0, mul_busy_o=1, counter decrements. At counter==1 the next state is RUN.
  - MUL_LAT=1: no hold ever.
- Priority, highest first: rst_i > branch flush > mul hold > load-use stall. Branch and mul cannot coexist in EX. A load-use condition during MUL_WAIT is re-evaluated after release.

## Timing
- Control outputs are registered: inst_i at edge n appears on ex_* after edge n.
- pc_write_o, ifid_write_o and ifid_flush_o are combinational from current state, the ex_* registers, inst_i and branch_taken_i. No registered path.
- Reset (synchronous): all ex_* = 0, illegal_o=0, state RUN, counter 0, mul_busy_o=0. While rst_i=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0.
- Reset asserted mid-MUL_WAIT aborts the hold at that edge.
- A load-use stall lasts exactly one cycle. A mul hold lasts exactly MUL_LAT-1 cycles.

## Configuration
- PIPE_CTRL_MUL_EN defined: mul is decoded and the hold FSM and counter are present.
- PIPE_CTRL_MUL_EN undefined: funct7=0000001 is illegal (bubble, illegal_o=1). The FSM and counter are removed. mul_busy_o is tied 0.

## Structure
- Shared package pipe_pkg holds:
  - ALU op localparams (ALU_ADD … ALU_CMP)
  - opcode constants
  - a packed struct ctrl_t (aluop, alusrc, memread, memwrite, memtoreg, regwrite, branch, illegal)
- One combinational sub-module, ctrl_decode: inst_i to ctrl_t plus rs1, rs2, rd and rs2-used. The hazard logic, FSM and ID/EX register live in pipe_ctrl.

## Test plan
- Reset: rst_i=1 for 2 cycles with add x1,x2,x3 on inst_i. Afterwards all ex_* = 0, pc_write_o=1, then ex_aluop_o=000, ex_regwrite_o=1, ex_rd_o=1.
- Load-use: lw x5,0(x1) followed by add x6,x5,x2. One cycle with pc_write_o=0, ifid_write_o=0, then a bubble in EX, then the add with ex_rd_o=6. The same sequence with rd=x0 gives no stall.
- sw rs2 hazard: lw x5 then sw x5,0(x7) stalls one cycle. lw x5 then addi x8,x9,1 gives no stall.
- Branch flush: beq in EX with branch_taken_i=1 and a lw-use pair in ID. ifid_flush_o=1, pc_write_o=1, bubble in EX. The flush wins over the stall.
- Mul hold, MUL_LAT=3: mul x4,x1,x2 then or x3,x4,x5. ex_aluop_o stays 101 for 3 cycles, mul_busy_o=1 for 2 cycles, then ex_aluop_o=010. Asserting rst_i in the second hold cycle clears everything at the next edge.
- Config off: without PIPE_CTRL_MUL_EN, mul gives illegal_o=1, all other control 0, and mul_busy_o stays 0. Opcode 1111111 gives illegal_o=1 in both builds.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared ALU op codes, opcodes and control bundle for the RV32 pipeline control
package pipe_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_CMP = 3'b110;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [2:0] aluop;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {
        S_RUN,
        S_MUL_WAIT
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - ID-stage instruction decoder; mul is decoded only with PIPE_CTRL_MUL_EN
import pipe_pkg::*;

module ctrl_decode #(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       inst_i,
    input  logic              valid_i,
    output ctrl_t             ctrl_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              rs2_used_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    assign rs1_o      = REG_AW'(inst_i[19:15]);
    assign rs2_o      = REG_AW'(inst_i[24:20]);
    assign rs2_used_o = opcode inside {OP_RTYPE, OP_STORE, OP_BRANCH};

    always_comb begin
        ctrl_o = '0;
        if (valid_i) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl_o.regwrite = 1'b1;
                    case ({funct7, funct3})
                        {F7_BASE, 3'b000}: ctrl_o.aluop = ALU_ADD;
                        {F7_SUB,  3'b000}: ctrl_o.aluop = ALU_SUB;
                        {F7_BASE, 3'b111}: ctrl_o.aluop = ALU_AND;
                        {F7_BASE, 3'b110}: ctrl_o.aluop = ALU_OR;
`ifdef PIPE_CTRL_MUL_EN
                        {F7_MUL,  3'b000}: ctrl_o.aluop = ALU_MUL;
`endif
                        default:           ctrl_o.illegal = 1'b1;
                    endcase
                end
                OP_IMM: begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.illegal  = (funct3 != 3'b000);
                end
                OP_LOAD: begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.memread  = 1'b1;
                    ctrl_o.memtoreg = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.illegal  = (funct3 != 3'b010);
                end
                OP_STORE: begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.memwrite = 1'b1;
                    ctrl_o.illegal  = (funct3 != 3'b010);
                end
                OP_BRANCH: begin
                    ctrl_o.aluop   = ALU_CMP;
                    ctrl_o.branch  = 1'b1;
                    ctrl_o.illegal = (funct3 != 3'b000);
                end
                default: ctrl_o.illegal = 1'b1;
            endcase
            // An undecodable instruction travels on as a bubble that only carries the flag
            if (ctrl_o.illegal) begin
                ctrl_o         = '0;
                ctrl_o.illegal = 1'b1;
            end
        end
    end

    assign rd_o = ctrl_o.regwrite ? REG_AW'(inst_i[11:7]) : '0;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - decode, ID/EX control register and hazard control; mul hold with PIPE_CTRL_MUL_EN
import pipe_pkg::*;

module pipe_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int REG_AW  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       inst_i,
    input  logic              id_valid_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic [2:0]        ex_aluop_o,
    output logic              ex_alusrc_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_regwrite_o,
    output logic              ex_branch_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              mul_busy_o,
    output logic              illegal_o
);

    ctrl_t             dec_ctrl;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_rs2_used;

    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              load_use;
    logic              hold;

    ctrl_decode #(.REG_AW(REG_AW)) u_decode (
        .inst_i     (inst_i),
        .valid_i    (id_valid_i),
        .ctrl_o     (dec_ctrl),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .rd_o       (dec_rd),
        .rs2_used_o (dec_rs2_used)
    );

    assign load_use = ex_ctrl_q.memread && (ex_rd_q != '0) &&
                      ((ex_rd_q == dec_rs1) || (dec_rs2_used && (ex_rd_q == dec_rs2)));

    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        ex_ctrl_d    = dec_ctrl;
        ex_rd_d      = dec_rd;
        if (rst_i) begin
            ex_ctrl_d = '0;
            ex_rd_d   = '0;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            ex_ctrl_d    = '0;
            ex_rd_d      = '0;
        end else if (hold) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            ex_ctrl_d    = ex_ctrl_q;
            ex_rd_d      = ex_rd_q;
        end else if (load_use) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            ex_ctrl_d    = '0;
            ex_rd_d      = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctrl_q <= '0;
            ex_rd_q   <= '0;
        end else begin
            ex_ctrl_q <= ex_ctrl_d;
            ex_rd_q   <= ex_rd_d;
        end
    end

`ifdef PIPE_CTRL_MUL_EN
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_busy_q, mul_busy_d;

    assign hold = (state_q == S_MUL_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                // ex_ctrl_d already excludes bubbles forced by reset, flush or stall
                if ((MUL_LAT > 1) && (ex_ctrl_d.aluop == ALU_MUL)) begin
                    state_d = S_MUL_WAIT;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                end
            end
            S_MUL_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (branch_taken_i || (cnt_q == CNT_W'(1))) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
        mul_busy_d = (state_d == S_MUL_WAIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            mul_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_busy_q <= mul_busy_d;
        end
    end

    assign mul_busy_o = mul_busy_q;
`else
    assign hold       = 1'b0;
    assign mul_busy_o = 1'b0;
`endif

    assign ex_aluop_o    = ex_ctrl_q.aluop;
    assign ex_alusrc_o   = ex_ctrl_q.alusrc;
    assign ex_memread_o  = ex_ctrl_q.memread;
    assign ex_memwrite_o = ex_ctrl_q.memwrite;
    assign ex_memtoreg_o = ex_ctrl_q.memtoreg;
    assign ex_regwrite_o = ex_ctrl_q.regwrite;
    assign ex_branch_o   = ex_ctrl_q.branch;
    assign ex_rd_o       = ex_rd_q;
    assign illegal_o     = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against an instruction-level model
module tb_pipe_ctrl;

    localparam int MUL_LAT = 3;
    localparam int REG_AW  = 5;
`ifdef PIPE_CTRL_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef enum int {K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_ADDI, K_LW, K_SW, K_BEQ, K_ILL} kind_e;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [31:0]       inst_i = '0;
    logic              id_valid_i = 1'b0;
    logic              branch_taken_i = 1'b0;
    logic              pc_write_o, ifid_write_o, ifid_flush_o;
    logic [2:0]        ex_aluop_o;
    logic              ex_alusrc_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
    logic              ex_regwrite_o, ex_branch_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic              mul_busy_o, illegal_o;

    pipe_ctrl #(.MUL_LAT(MUL_LAT), .REG_AW(REG_AW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inst_i         (inst_i),
        .id_valid_i     (id_valid_i),
        .branch_taken_i (branch_taken_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .ex_aluop_o     (ex_aluop_o),
        .ex_alusrc_o    (ex_alusrc_o),
        .ex_memread_o   (ex_memread_o),
        .ex_memwrite_o  (ex_memwrite_o),
        .ex_memtoreg_o  (ex_memtoreg_o),
        .ex_regwrite_o  (ex_regwrite_o),
        .ex_branch_o    (ex_branch_o),
        .ex_rd_o        (ex_rd_o),
        .mul_busy_o     (mul_busy_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    int    n_checks = 0;
    int    n_errors = 0;
    kind_e m_kind = K_NOP, nx_kind = K_NOP;
    logic [4:0] m_rd = '0, nx_rd = '0;
    int    m_hold = 0, nx_hold = 0;
    bit    m_known = 1'b0, nx_known = 1'b0;
    bit    chk_en = 1'b0;
    logic  exp_pcw, exp_ifw, exp_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b1100011};
    endfunction

    function automatic kind_e classify(input logic [31:0] w, input logic valid);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (!valid) return K_NOP;
        case (op)
            7'b0110011: begin
                if (f3 == 3'd0 && f7 == 7'd0)           return K_ADD;
                if (f3 == 3'd0 && f7 == 7'b0100000)     return K_SUB;
                if (f3 == 3'd7 && f7 == 7'd0)           return K_AND;
                if (f3 == 3'd6 && f7 == 7'd0)           return K_OR;
                if (f3 == 3'd0 && f7 == 7'd1 && MUL_ON) return K_MUL;
                return K_ILL;
            end
            7'b0010011: return (f3 == 3'd0) ? K_ADDI : K_ILL;
            7'b0000011: return (f3 == 3'd2) ? K_LW : K_ILL;
            7'b0100011: return (f3 == 3'd2) ? K_SW : K_ILL;
            7'b1100011: return (f3 == 3'd0) ? K_BEQ : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    // {aluop, alusrc, memread, memwrite, memtoreg, regwrite, branch, illegal}
    function automatic logic [9:0] kind_ctrl(input kind_e k);
        case (k)
            K_ADD:   return 10'b000_0_0_0_0_1_0_0;
            K_SUB:   return 10'b011_0_0_0_0_1_0_0;
            K_AND:   return 10'b001_0_0_0_0_1_0_0;
            K_OR:    return 10'b010_0_0_0_0_1_0_0;
            K_MUL:   return 10'b101_0_0_0_0_1_0_0;
            K_ADDI:  return 10'b000_1_0_0_0_1_0_0;
            K_LW:    return 10'b000_1_1_0_1_1_0_0;
            K_SW:    return 10'b000_1_0_1_0_0_0_0;
            K_BEQ:   return 10'b110_0_0_0_0_0_1_0;
            K_ILL:   return 10'b000_0_0_0_0_0_0_1;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [4:0] dest(input kind_e k, input logic [31:0] w);
        if (k inside {K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_ADDI, K_LW}) return w[11:7];
        return 5'd0;
    endfunction

    function automatic bit uses_rs2(input logic [31:0] w);
        return (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0100011) || (w[6:0] == 7'b1100011);
    endfunction

    task automatic drive(input logic [31:0] w, input logic valid, input logic bt, input logic rst);
        kind_e k;
        bit    lu;
        inst_i         = w;
        id_valid_i     = valid;
        branch_taken_i = bt;
        rst_i          = rst;
        k  = classify(w, valid);
        lu = (m_kind == K_LW) && (m_rd != 5'd0) &&
             ((m_rd == w[19:15]) || (uses_rs2(w) && (m_rd == w[24:20])));
        exp_pcw   = 1'b1;
        exp_ifw   = 1'b1;
        exp_flush = !rst && bt;
        nx_known  = m_known;
        nx_kind   = k;
        nx_rd     = dest(k, w);
        nx_hold   = (k == K_MUL) ? MUL_LAT - 1 : 0;
        if (rst) begin
            nx_kind = K_NOP; nx_rd = '0; nx_hold = 0; nx_known = 1'b1;
        end else if (bt) begin
            nx_kind = K_NOP; nx_rd = '0; nx_hold = 0;
        end else if (m_hold > 0) begin
            exp_pcw = 1'b0; exp_ifw = 1'b0;
            nx_kind = m_kind; nx_rd = m_rd; nx_hold = m_hold - 1;
        end else if (lu) begin
            exp_pcw = 1'b0; exp_ifw = 1'b0;
            nx_kind = K_NOP; nx_rd = '0; nx_hold = 0;
        end
        chk_en = 1'b1;
        #2;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        m_kind  = nx_kind;
        m_rd    = nx_rd;
        m_hold  = nx_hold;
        m_known = nx_known;
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("pc_write", 32'(pc_write_o), 32'(exp_pcw));
            chk("ifid_write", 32'(ifid_write_o), 32'(exp_ifw));
            chk("ifid_flush", 32'(ifid_flush_o), 32'(exp_flush));
            if (m_known) begin
                chk("ex_ctrl", 32'({ex_aluop_o, ex_alusrc_o, ex_memread_o, ex_memwrite_o,
                                    ex_memtoreg_o, ex_regwrite_o, ex_branch_o, illegal_o}),
                    32'(kind_ctrl(m_kind)));
                chk("ex_rd", 32'(ex_rd_o), 32'(m_rd));
                chk("mul_busy", 32'(mul_busy_o), 32'(m_hold > 0));
            end
        end
    end

    initial begin
        logic [31:0] add_1_2_3, lw_5, lw_0, add_6_5_2, add_6_0_2, sw_5_7, addi_8_9;
        logic [31:0] beq_1_2, mul_4_1_2, or_3_4_5, bad_op;
        add_1_2_3 = enc_r(7'd0, 5'd3, 5'd2, 3'd0, 5'd1);
        lw_5      = enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011);
        lw_0      = enc_i(12'd0, 5'd1, 3'd2, 5'd0, 7'b0000011);
        add_6_5_2 = enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6);
        add_6_0_2 = enc_r(7'd0, 5'd2, 5'd0, 3'd0, 5'd6);
        sw_5_7    = enc_s(12'd0, 5'd5, 5'd7);
        addi_8_9  = enc_i(12'd1, 5'd9, 3'd0, 5'd8, 7'b0010011);
        beq_1_2   = enc_b(5'd2, 5'd1);
        mul_4_1_2 = enc_r(7'd1, 5'd2, 5'd1, 3'd0, 5'd4);
        or_3_4_5  = enc_r(7'd0, 5'd5, 5'd4, 3'd6, 5'd3);
        bad_op    = 32'hFFFF_FFFF;

        @(posedge clk_i);
        #1;
        // reset for two cycles with add x1,x2,x3 in ID
        drive(add_1_2_3, 1'b1, 1'b0, 1'b1);
        chk("rst_pc_write", 32'(pc_write_o), 32'd1);
        tick();
        drive(add_1_2_3, 1'b1, 1'b0, 1'b1);
        tick();
        drive(add_1_2_3, 1'b1, 1'b0, 1'b0);
        chk("rst_ex_regwrite", 32'(ex_regwrite_o), 32'd0);
        chk("rst_ex_rd", 32'(ex_rd_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        chk("post_rst_pc_write", 32'(pc_write_o), 32'd1);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk("add_aluop", 32'(ex_aluop_o), 32'd0);
        chk("add_regwrite", 32'(ex_regwrite_o), 32'd1);
        chk("add_rd", 32'(ex_rd_o), 32'd1);
        tick();

        // load-use on rs1, then the x0 case
        drive(lw_5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(add_6_5_2, 1'b1, 1'b0, 1'b0);
        chk("lu_pc_write", 32'(pc_write_o), 32'd0);
        chk("lu_ifid_write", 32'(ifid_write_o), 32'd0);
        tick();
        drive(add_6_5_2, 1'b1, 1'b0, 1'b0);
        chk("lu_bubble", 32'({ex_memread_o, ex_regwrite_o}), 32'd0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk("lu_add_rd", 32'(ex_rd_o), 32'd6);
        tick();
        drive(lw_0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(add_6_0_2, 1'b1, 1'b0, 1'b0);
        chk("lu_x0_pc_write", 32'(pc_write_o), 32'd1);
        tick();

        // store data hazard and a non-hazard addi
        drive(lw_5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(sw_5_7, 1'b1, 1'b0, 1'b0);
        chk("sw_lu_pc_write", 32'(pc_write_o), 32'd0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(lw_5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(addi_8_9, 1'b1, 1'b0, 1'b0);
        chk("addi_no_stall", 32'(pc_write_o), 32'd1);
        tick();

        // branch flush, then flush overriding a load-use
        drive(beq_1_2, 1'b1, 1'b0, 1'b0);
        tick();
        drive(lw_5, 1'b1, 1'b1, 1'b0);
        chk("br_flush", 32'(ifid_flush_o), 32'd1);
        chk("br_pc_write", 32'(pc_write_o), 32'd1);
        tick();
        drive(lw_5, 1'b1, 1'b0, 1'b0);
        chk("br_bubble", 32'({ex_memread_o, ex_branch_o, ex_regwrite_o}), 32'd0);
        tick();
        drive(add_6_5_2, 1'b1, 1'b1, 1'b0);
        chk("flush_over_lu_flush", 32'(ifid_flush_o), 32'd1);
        chk("flush_over_lu_pc", 32'(pc_write_o), 32'd1);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk("flush_over_lu_bubble", 32'(ex_regwrite_o), 32'd0);
        tick();

        if (MUL_ON) begin
            drive(mul_4_1_2, 1'b1, 1'b0, 1'b0);
            tick();
            for (int i = 0; i < 3; i++) begin
                drive(or_3_4_5, 1'b1, 1'b0, 1'b0);
                chk("mul_aluop", 32'(ex_aluop_o), 32'd5);
                chk("mul_busy_seq", 32'(mul_busy_o), (i < 2) ? 32'd1 : 32'd0);
                chk("mul_pc_write", 32'(pc_write_o), (i < 2) ? 32'd0 : 32'd1);
                tick();
            end
            drive(32'h0, 1'b0, 1'b0, 1'b0);
            chk("mul_then_or", 32'(ex_aluop_o), 32'd2);
            tick();
            drive(mul_4_1_2, 1'b1, 1'b0, 1'b0);
            tick();
            drive(or_3_4_5, 1'b1, 1'b0, 1'b0);
            tick();
            drive(or_3_4_5, 1'b1, 1'b0, 1'b1);
            chk("mul_rst_busy_before", 32'(mul_busy_o), 32'd1);
            tick();
            drive(32'h0, 1'b0, 1'b0, 1'b0);
            chk("mul_rst_busy_after", 32'(mul_busy_o), 32'd0);
            chk("mul_rst_aluop", 32'(ex_aluop_o), 32'd0);
            chk("mul_rst_pc_write", 32'(pc_write_o), 32'd1);
            tick();
        end else begin
            drive(mul_4_1_2, 1'b1, 1'b0, 1'b0);
            tick();
            drive(32'h0, 1'b0, 1'b0, 1'b0);
            chk("mul_off_illegal", 32'(illegal_o), 32'd1);
            chk("mul_off_ctrl", 32'({ex_aluop_o, ex_regwrite_o, ex_alusrc_o}), 32'd0);
            chk("mul_off_busy", 32'(mul_busy_o), 32'd0);
            tick();
        end
        drive(bad_op, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk("bad_opcode_illegal", 32'(illegal_o), 32'd1);
        tick();

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] w;
            logic [4:0]  a, b, d;
            logic        r, bt;
            a = 5'($urandom_range(0, 7));
            b = 5'($urandom_range(0, 7));
            d = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 11))
                0:  w = enc_r(7'd0, b, a, 3'd0, d);
                1:  w = enc_r(7'b0100000, b, a, 3'd0, d);
                2:  w = enc_r(7'd0, b, a, 3'd7, d);
                3:  w = enc_r(7'd0, b, a, 3'd6, d);
                4:  w = enc_r(7'd1, b, a, 3'd0, d);
                5:  w = enc_i(12'($urandom), a, 3'd0, d, 7'b0010011);
                6:  w = enc_i(12'($urandom), a, 3'd2, d, 7'b0000011);
                7:  w = enc_i(12'($urandom), a, 3'($urandom), d, 7'b0000011);
                8:  w = enc_s(12'($urandom), b, a);
                9:  w = enc_b(b, a);
                10: w = $urandom;
                default: w = enc_r(7'($urandom), b, a, 3'($urandom), d);
            endcase
            r  = ($urandom_range(0, 99) == 0);
            bt = (m_kind == K_BEQ) && ($urandom_range(0, 1) == 1);
            drive(w, ($urandom_range(0, 9) != 0), bt, r);
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
